// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and the instruction execution unit.
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic        [4:0]  address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef logic signed [63:0] result_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        EXEC   = 3'd2,
        OUTPUT = 3'd3,
        FINISH = 3'd4
    } exec_state_t;

    // Batch statistics stick at the top of their 6-bit range instead of wrapping.
    function automatic logic [5:0] satInc(input logic [5:0] value);
        return (value == 6'd63) ? value : value + 6'd1;
    endfunction

endpackage

// File: rtl/instr_alu.sv
// Combinational opcode arithmetic; operands are sign-extended to 64 bits first
// so MULT keeps the full product and DIV of the most negative value cannot overflow.
module instr_alu
    import instr_register_pkg::*;
(
    input  instruction_t i_instruction,
    output result_t      o_result,
    output logic         o_div_by_zero
);

    result_t w_opA;
    result_t w_opB;

    assign w_opA = {{32{i_instruction.op_a[31]}}, i_instruction.op_a};
    assign w_opB = {{32{i_instruction.op_b[31]}}, i_instruction.op_b};

    always_comb begin
        o_result      = '0;
        o_div_by_zero = 1'b0;
        case (i_instruction.opc)
            ZERO:  o_result = '0;
            PASSA: o_result = w_opA;
            PASSB: o_result = w_opB;
            ADD:   o_result = w_opA + w_opB;
            SUB:   o_result = w_opA - w_opB;
            MULT:  o_result = w_opA * w_opB;
            DIV: begin
                if (w_opB == '0) begin
                    o_div_by_zero = 1'b1;
                end else begin
                    o_result = w_opA / w_opB;
                end
            end
            MOD: begin
                if (w_opB == '0) begin
                    o_div_by_zero = 1'b1;
                end else begin
                    o_result = w_opA % w_opB;
                end
            end
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/instr_exec_unit.sv
// Batch instruction executor: fetches slots from instr_register, runs them through
// instr_alu and hands results out on a valid/ready port. Optional INSTR_EXEC_STATS_EN.
module instr_exec_unit
    import instr_register_pkg::*;
#(
    parameter int RESULT_W = 64
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  address_t                   first_addr,
    input  logic [5:0]                 num_instr,
    output address_t                   read_pointer,
    input  instruction_t               instruction_word,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic signed [RESULT_W-1:0] result,
    output address_t                   result_addr,
    output logic                       div_by_zero,
    output logic                       busy,
    output logic                       done
`ifdef INSTR_EXEC_STATS_EN
    ,
    output logic [5:0]                 results_count,
    output logic [5:0]                 div0_count
`endif
);

    exec_state_t                r_state;
    address_t                   r_readPointer;
    logic [5:0]                 r_remaining;
    instruction_t               r_instr;
    logic signed [RESULT_W-1:0] r_result;
    address_t                   r_resultAddr;
    logic                       r_divByZero;
    logic                       r_resultValid;
    logic                       r_busy;
    logic                       r_done;

    result_t                    w_aluResult;
    logic                       w_aluDivZero;
    logic signed [RESULT_W-1:0] w_resultExt;
    logic                       w_handshake;

    instr_alu u_alu (
        .i_instruction (r_instr),
        .o_result      (w_aluResult),
        .o_div_by_zero (w_aluDivZero)
    );

    // Signed size cast: sign-extends for wide results, truncates for narrow ones.
    assign w_resultExt = RESULT_W'(w_aluResult);
    assign w_handshake = (r_state == OUTPUT) && result_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_readPointer <= '0;
            r_remaining   <= '0;
            r_instr       <= '0;
            r_result      <= '0;
            r_resultAddr  <= '0;
            r_divByZero   <= 1'b0;
            r_resultValid <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        if (num_instr != 6'd0) begin
                            r_readPointer <= first_addr;
                            r_remaining   <= num_instr;
                            r_state       <= FETCH;
                        end else begin
                            r_state <= FINISH;
                            r_done  <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    r_instr <= instruction_word;
                    r_state <= EXEC;
                end
                EXEC: begin
                    r_result      <= w_resultExt;
                    r_divByZero   <= w_aluDivZero;
                    r_resultAddr  <= r_readPointer;
                    r_resultValid <= 1'b1;
                    r_state       <= OUTPUT;
                end
                OUTPUT: begin
                    // Result, address and flag hold untouched until the consumer takes them.
                    if (result_ready) begin
                        r_resultValid <= 1'b0;
                        r_remaining   <= r_remaining - 6'd1;
                        r_readPointer <= r_readPointer + 5'd1;
                        if (r_remaining > 6'd1) begin
                            r_state <= FETCH;
                        end else begin
                            r_state <= FINISH;
                            r_done  <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef INSTR_EXEC_STATS_EN
    logic [5:0] r_resultsCount;
    logic [5:0] r_div0Count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_resultsCount <= '0;
            r_div0Count    <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_resultsCount <= '0;
            r_div0Count    <= '0;
        end else if (w_handshake) begin
            r_resultsCount <= satInc(r_resultsCount);
            if (r_divByZero) begin
                r_div0Count <= satInc(r_div0Count);
            end
        end
    end

    assign results_count = r_resultsCount;
    assign div0_count    = r_div0Count;
`endif

    assign read_pointer = r_readPointer;
    assign result_valid = r_resultValid;
    assign result       = r_result;
    assign result_addr  = r_resultAddr;
    assign div_by_zero  = r_divByZero;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_instr_exec_unit.sv
// Self-checking bench for instr_exec_unit: directed scenarios plus random batches
// scored against an arithmetic reference model of the instruction register contents.
module tb_instr_exec_unit;
    import instr_register_pkg::*;

    localparam int RESULT_W = 64;

    logic                       clk = 1'b0;
    logic                       reset_n;
    logic                       start;
    address_t                   first_addr;
    logic [5:0]                 num_instr;
    address_t                   read_pointer;
    instruction_t               instruction_word;
    logic                       result_valid;
    logic                       result_ready;
    logic signed [RESULT_W-1:0] result;
    address_t                   result_addr;
    logic                       div_by_zero;
    logic                       busy;
    logic                       done;
`ifdef INSTR_EXEC_STATS_EN
    logic [5:0]                 results_count;
    logic [5:0]                 div0_count;
`endif

    instruction_t mem [32];
    int errorCount = 0;
    int checkCount = 0;

    assign instruction_word = mem[read_pointer];

    always #5 clk = ~clk;

    instr_exec_unit #(.RESULT_W(RESULT_W)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .first_addr       (first_addr),
        .num_instr        (num_instr),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .result           (result),
        .result_addr      (result_addr),
        .div_by_zero      (div_by_zero),
        .busy             (busy),
        .done             (done)
`ifdef INSTR_EXEC_STATS_EN
        ,
        .results_count    (results_count),
        .div0_count       (div0_count)
`endif
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference semantics of one instruction, straight from the opcode definitions.
    function automatic void modelExec(input instruction_t ins, output longint res, output bit dz);
        longint a = ins.op_a;
        longint b = ins.op_b;
        dz  = 1'b0;
        res = 0;
        case (ins.opc)
            ZERO:  res = 0;
            PASSA: res = a;
            PASSB: res = b;
            ADD:   res = a + b;
            SUB:   res = a - b;
            MULT:  res = a * b;
            DIV:   if (b == 0) dz = 1'b1; else res = a / b;
            MOD:   if (b == 0) dz = 1'b1; else res = a % b;
            default: res = 0;
        endcase
    endfunction

    function automatic operand_t randOperand();
        if ($urandom_range(0, 2) == 0) return operand_t'($urandom);
        return operand_t'(int'($urandom_range(0, 60)) - 30);
    endfunction

    function automatic instruction_t randInstr();
        instruction_t ins;
        ins.opc  = opcode_t'($urandom_range(0, 7));
        ins.op_a = randOperand();
        ins.op_b = ($urandom_range(0, 4) == 0) ? operand_t'(0) : randOperand();
        return ins;
    endfunction

    task automatic applyStimulus(input address_t fa, input int n, input int stall, input bit pokeStart);
        longint   expRes[$];
        bit       expDz[$];
        address_t expAddr[$];
        longint   r;
        bit       dz;
        address_t a;
        int       cnt;
        int       dzCount = 0;

        for (int k = 0; k < n; k++) begin
            a = address_t'(fa + k);
            modelExec(mem[a], r, dz);
            expRes.push_back(r);
            expDz.push_back(dz);
            expAddr.push_back(a);
            if (dz) dzCount++;
        end

        result_ready = (stall == 0);
        first_addr   = fa;
        num_instr    = 6'(n);
        start        = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("busy_after_start", busy, 1);

        if (n == 0) begin
            checkOutput("done_zero_batch", done, 1);
            checkOutput("valid_zero_batch", result_valid, 0);
            start      = 1'b1;
            first_addr = fa + 5'd1;
            num_instr  = 6'd1;
            tick();
            start = 1'b0;
            checkOutput("done_single_pulse", done, 0);
            checkOutput("idle_after_zero", busy, 0);
            tick();
            checkOutput("start_in_finish_ignored", busy, 0);
            checkOutput("no_valid_after_zero", result_valid, 0);
            return;
        end

        if (pokeStart) begin
            start      = 1'b1;
            first_addr = ~fa;
            num_instr  = 6'd7;
        end

        cnt = 1;
        for (int k = 0; k < n; k++) begin
            while (!result_valid && cnt < 12) begin
                tick();
                start = 1'b0;
                cnt++;
            end
            checkOutput("latency", 64'(cnt), 64'd3);
            checkOutput("result", result, expRes[k]);
            checkOutput("result_addr", result_addr, expAddr[k]);
            checkOutput("div_by_zero", div_by_zero, expDz[k]);
            checkOutput("read_pointer", read_pointer, expAddr[k]);
            for (int s = 0; s < stall; s++) begin
                tick();
                checkOutput("stall_valid", result_valid, 1);
                checkOutput("stall_result", result, expRes[k]);
                checkOutput("stall_addr", result_addr, expAddr[k]);
                checkOutput("stall_pointer", read_pointer, expAddr[k]);
            end
            result_ready = 1'b1;
            tick();
            result_ready = (stall == 0);
            checkOutput("valid_drop", result_valid, 0);
            checkOutput("ptr_advance", read_pointer, address_t'(expAddr[k] + 5'd1));
            cnt = 1;
        end

        checkOutput("done_pulse", done, 1);
        checkOutput("busy_in_finish", busy, 1);
        tick();
        checkOutput("done_cleared", done, 0);
        checkOutput("busy_cleared", busy, 0);
`ifdef INSTR_EXEC_STATS_EN
        checkOutput("results_count", results_count, 64'((n > 63) ? 63 : n));
        checkOutput("div0_count", div0_count, 64'(dzCount));
`endif
    endtask

    task automatic resetMidBatch();
        int cnt = 0;
        for (int k = 8; k < 12; k++) mem[k] = randInstr();
        result_ready = 1'b0;
        first_addr   = 5'd8;
        num_instr    = 6'd4;
        start        = 1'b1;
        tick();
        start = 1'b0;
        while (!result_valid && cnt < 12) begin
            tick();
            cnt++;
        end
        checkOutput("reset_test_reached_output", result_valid, 1);
        reset_n = 1'b0;
        tick();
        checkOutput("rst_valid", result_valid, 0);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_addr", result_addr, 0);
        checkOutput("rst_dz", div_by_zero, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_pointer", read_pointer, 0);
        reset_n      = 1'b1;
        result_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("post_reset_no_done", done, 0);
            checkOutput("post_reset_no_valid", result_valid, 0);
        end
`ifdef INSTR_EXEC_STATS_EN
        checkOutput("rst_results_count", results_count, 0);
`endif
    endtask

    initial begin
        reset_n      = 1'b0;
        start        = 1'b0;
        result_ready = 1'b0;
        first_addr   = '0;
        num_instr    = '0;
        for (int k = 0; k < 32; k++) mem[k] = randInstr();
        tick();
        tick();
        checkOutput("reset_valid", result_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_pointer", read_pointer, 0);
        checkOutput("reset_result", result, 0);
        reset_n = 1'b1;
        tick();

        $display("[TB] single ADD");
        mem[0] = '{opc: ADD, op_a: 5, op_b: 7};
        applyStimulus(5'd0, 1, 0, 1'b0);

        $display("[TB] wrap-around batch");
        mem[30] = '{opc: SUB,   op_a: 3,  op_b: 10};
        mem[31] = '{opc: MULT,  op_a: -4, op_b: 6};
        mem[0]  = '{opc: PASSB, op_a: 0,  op_b: 9};
        applyStimulus(5'd30, 3, 0, 1'b1);

        $display("[TB] divide by zero");
        mem[4] = '{opc: DIV, op_a: 20, op_b: 0};
        mem[5] = '{opc: MOD, op_a: 20, op_b: 6};
        applyStimulus(5'd4, 2, 0, 1'b0);

        $display("[TB] back-pressure");
        applyStimulus(5'd10, 3, 5, 1'b0);

        $display("[TB] empty batch");
        applyStimulus(5'd3, 0, 0, 1'b0);

        $display("[TB] reset mid-batch");
        resetMidBatch();

        $display("[TB] random batches");
        for (int t = 0; t < 25; t++) begin
            for (int k = 0; k < 32; k++) begin
                if ($urandom_range(0, 1) == 0) mem[k] = randInstr();
            end
            applyStimulus(address_t'($urandom_range(0, 31)),
                          (t == 12) ? 32 : int'($urandom_range(0, 6)),
                          int'($urandom_range(0, 2)),
                          1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
